assoc_mem_seq: RTL and testbench

//  Parametrised sequential associative memory for sparse HDC inference.

---
 rtl/hdc_pkg.sv | 23 ++
 rtl/hdc_popcount.sv | 17 +
 rtl/assoc_mem_seq.sv | 124 ++++++++++++
 tb/tb_assoc_mem_seq.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/hdc_pkg.sv
// Shared HDC definitions: default geometry, associative-memory FSM encoding
// and a constant-friendly clog2 helper.
package hdc_pkg;

    localparam int HV_W_DEF    = 50;
    localparam int N_CLASS_DEF = 26;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/hdc_popcount.sv
// Combinational population count of a W-bit vector; also used by the encoder.
module hdc_popcount #(
    parameter int W     = 8,
    parameter int OUT_W = 4
) (
    input  logic [W-1:0]     i_bits,
    output logic [OUT_W-1:0] o_count
);

    always_comb begin
        o_count = '0;
        for (int i = 0; i < W; i++) begin
            o_count = o_count + OUT_W'(i_bits[i]);
        end
    end

endmodule

// File: rtl/assoc_mem_seq.sv
// Sequential associative memory: scans one stored class per cycle, keeps the
// strict-greater argmax of popcount(query & class) and counts delivered results.
module assoc_mem_seq
    import hdc_pkg::*;
#(
    parameter int HV_W      = HV_W_DEF,
    parameter int N_CLASS   = N_CLASS_DEF,
    parameter int CLS_W     = clog2(N_CLASS),
    parameter int SCORE_W   = clog2(HV_W + 1),
    parameter int MIN_SCORE = 0,
    parameter int CNT_W     = 16
) (
    input  logic               clk,
    input  logic               nrst,
    input  logic               wr_en,
    input  logic [CLS_W-1:0]   wr_addr,
    input  logic [HV_W-1:0]    wr_hv,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [HV_W-1:0]    query_hv,
    input  logic [CLS_W-1:0]   query_class,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [CLS_W-1:0]   inference,
    output logic [SCORE_W-1:0] best_score,
    output logic               reject,
    output logic               busy,
    output logic [CNT_W-1:0]   query_cnt,
    output logic [CNT_W-1:0]   correct_cnt,
    input  logic               stat_clr
);

    state_t             r_state;
    logic [CLS_W-1:0]   r_idx;
    logic [CLS_W-1:0]   r_best;
    logic [SCORE_W-1:0] r_best_score;
    logic [HV_W-1:0]    r_query;
    logic [CLS_W-1:0]   r_label;
    logic [CNT_W-1:0]   r_query_cnt;
    logic [CNT_W-1:0]   r_correct_cnt;
    logic [HV_W-1:0]    r_mem [N_CLASS];

    logic [SCORE_W-1:0] w_score;
    logic               w_last;
    logic               w_out_hs;
    logic               w_correct;

    hdc_popcount #(
        .W     (HV_W),
        .OUT_W (SCORE_W)
    ) u_popcount (
        .i_bits  (r_query & r_mem[r_idx]),
        .o_count (w_score)
    );

    assign w_last    = (r_idx == CLS_W'(N_CLASS - 1));
    assign w_out_hs  = (r_state == ST_DONE) && out_ready;
    assign w_correct = !reject && (r_best == r_label);

    assign in_ready    = (r_state == ST_IDLE);
    assign out_valid   = (r_state == ST_DONE);
    assign busy        = (r_state != ST_IDLE);
    assign inference   = r_best;
    assign best_score  = r_best_score;
    // Gated by out_valid so reject stays low outside a presented result.
    assign reject      = out_valid && (int'(r_best_score) < MIN_SCORE);
    assign query_cnt   = r_query_cnt;
    assign correct_cnt = r_correct_cnt;

    // Memory is frozen outside IDLE so a scan always sees one consistent class set.
    always_ff @(posedge clk) begin
        if (r_state == ST_IDLE && wr_en && int'(wr_addr) < N_CLASS) begin
            r_mem[wr_addr] <= wr_hv;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state       <= ST_IDLE;
            r_idx         <= '0;
            r_best        <= '0;
            r_best_score  <= '0;
            r_query       <= '0;
            r_label       <= '0;
            r_query_cnt   <= '0;
            r_correct_cnt <= '0;
        end else begin
            if (stat_clr) begin
                r_query_cnt   <= '0;
                r_correct_cnt <= '0;
            end else if (w_out_hs) begin
                if (!(&r_query_cnt)) r_query_cnt <= r_query_cnt + 1'b1;
                if (w_correct && !(&r_correct_cnt)) r_correct_cnt <= r_correct_cnt + 1'b1;
            end

            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_query      <= query_hv;
                        r_label      <= query_class;
                        r_idx        <= '0;
                        r_best       <= '0;
                        r_best_score <= '0;
                        r_state      <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    // Strict compare keeps the lowest index on ties.
                    if (w_score > r_best_score) begin
                        r_best       <= r_idx;
                        r_best_score <= w_score;
                    end
                    if (w_last) r_state <= ST_DONE;
                    else        r_idx   <= r_idx + 1'b1;
                end
                ST_DONE: begin
                    if (out_ready) r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_assoc_mem_seq.sv
// Directed bench for assoc_mem_seq: table of queries over the demo class set
// plus hand sequences for stall, frozen writes, reset abort and counter clear.
module tb_assoc_mem_seq;

    localparam int HV_W = 50;
    localparam int NC   = 26;

    logic        clk;
    logic        nrst;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [49:0] wr_hv;
    logic        in_valid;
    logic [49:0] query_hv;
    logic [4:0]  query_class;
    logic        out_ready;
    logic        stat_clr;

    logic        o0_in_ready, o0_out_valid, o0_reject, o0_busy;
    logic [4:0]  o0_inference;
    logic [5:0]  o0_best_score;
    logic [15:0] o0_query_cnt, o0_correct_cnt;
    logic        o1_in_ready, o1_out_valid, o1_reject, o1_busy;
    logic [4:0]  o1_inference;
    logic [5:0]  o1_best_score;
    logic [15:0] o1_query_cnt, o1_correct_cnt;

    int n_checks = 0;
    int n_err    = 0;

    assoc_mem_seq dut0 (
        .clk(clk), .nrst(nrst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_hv(wr_hv),
        .in_valid(in_valid), .in_ready(o0_in_ready), .query_hv(query_hv),
        .query_class(query_class), .out_valid(o0_out_valid), .out_ready(out_ready),
        .inference(o0_inference), .best_score(o0_best_score), .reject(o0_reject),
        .busy(o0_busy), .query_cnt(o0_query_cnt), .correct_cnt(o0_correct_cnt),
        .stat_clr(stat_clr)
    );

    assoc_mem_seq #(.MIN_SCORE(8)) dut1 (
        .clk(clk), .nrst(nrst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_hv(wr_hv),
        .in_valid(in_valid), .in_ready(o1_in_ready), .query_hv(query_hv),
        .query_class(query_class), .out_valid(o1_out_valid), .out_ready(out_ready),
        .inference(o1_inference), .best_score(o1_best_score), .reject(o1_reject),
        .busy(o1_busy), .query_cnt(o1_query_cnt), .correct_cnt(o1_correct_cnt),
        .stat_clr(stat_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [49:0] q;
        logic [4:0]  lbl;
        logic [4:0]  inf;
        logic [5:0]  score;
        logic        rej1;
        logic [15:0] qc;
        logic [15:0] c0;
        logic [15:0] c1;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic write_cls(input int a, input logic [49:0] d);
        @(negedge clk);
        wr_en   = 1'b1;
        wr_addr = 5'(a);
        wr_hv   = d;
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    task automatic start_query(input logic [49:0] q, input logic [4:0] l);
        @(negedge clk);
        chk("in_ready_idle", {63'd0, o0_in_ready}, 64'd1);
        in_valid    = 1'b1;
        query_hv    = q;
        query_class = l;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (n < 60) begin
            @(posedge clk);
            #1;
            n++;
            if (o0_out_valid) break;
        end
    endtask

    task automatic handshake(input logic clr);
        @(negedge clk);
        out_ready = 1'b1;
        stat_clr  = clr;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        stat_clr  = 1'b0;
    endtask

    function automatic logic [49:0] demo_cls(input int a);
        case (a)
            0:       return 50'hFFFF;
            9:       return 50'hF_FFFF_FFFF;
            16:      return 50'hFFFF_FFFF;
            23, 24:  return 50'hF0_0000_0001;
            25:      return 50'hF0_0000_0000;
            default: return 50'h0;
        endcase
    endfunction

    initial begin
        int n;

        vecs[0] = '{50'hFF_FFFF_FFFF,        5'd9,  5'd9,  6'd36, 1'b0, 16'd1, 16'd1, 16'd1};
        vecs[1] = '{50'hF0_0000_0001,        5'd5,  5'd23, 6'd5,  1'b1, 16'd2, 16'd1, 16'd1};
        vecs[2] = '{50'h1,                   5'd0,  5'd0,  6'd1,  1'b1, 16'd3, 16'd2, 16'd1};
        vecs[3] = '{50'h0,                   5'd0,  5'd0,  6'd0,  1'b1, 16'd4, 16'd3, 16'd1};
        vecs[4] = '{50'hFFFF_0000,           5'd16, 5'd9,  6'd16, 1'b0, 16'd5, 16'd3, 16'd1};
        vecs[5] = '{50'h3_FFFF_FFFF_FFFF,    5'd9,  5'd9,  6'd36, 1'b0, 16'd6, 16'd4, 16'd2};

        nrst = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_hv = '0; in_valid = 1'b0;
        query_hv = '0; query_class = '0; out_ready = 1'b0; stat_clr = 1'b0;
        #12;
        chk("rst_out_valid", {63'd0, o0_out_valid}, 64'd0);
        chk("rst_reject1",   {63'd0, o1_reject}, 64'd0);
        chk("rst_busy",      {63'd0, o0_busy}, 64'd0);
        chk("rst_inference", {59'd0, o0_inference}, 64'd0);
        chk("rst_score",     {58'd0, o0_best_score}, 64'd0);
        chk("rst_qcnt",      {48'd0, o0_query_cnt}, 64'd0);
        chk("rst_ccnt",      {48'd0, o0_correct_cnt}, 64'd0);
        @(negedge clk);
        nrst = 1'b1;

        for (int a = 0; a < NC; a++) write_cls(a, demo_cls(a));

        for (int i = 0; i < 6; i++) begin
            start_query(vecs[i].q, vecs[i].lbl);
            wait_done(n);
            chk($sformatf("v%0d_latency", i), 64'(n), 64'd26);
            chk($sformatf("v%0d_inference", i), {59'd0, o0_inference}, {59'd0, vecs[i].inf});
            chk($sformatf("v%0d_score", i), {58'd0, o0_best_score}, {58'd0, vecs[i].score});
            chk($sformatf("v%0d_reject0", i), {63'd0, o0_reject}, 64'd0);
            chk($sformatf("v%0d_reject1", i), {63'd0, o1_reject}, {63'd0, vecs[i].rej1});
            chk($sformatf("v%0d_in_ready_done", i), {63'd0, o0_in_ready}, 64'd0);
            handshake(1'b0);
            chk($sformatf("v%0d_qcnt", i), {48'd0, o0_query_cnt}, {48'd0, vecs[i].qc});
            chk($sformatf("v%0d_ccnt0", i), {48'd0, o0_correct_cnt}, {48'd0, vecs[i].c0});
            chk($sformatf("v%0d_ccnt1", i), {48'd0, o1_correct_cnt}, {48'd0, vecs[i].c1});
            chk($sformatf("v%0d_out_valid_after", i), {63'd0, o0_out_valid}, 64'd0);
        end

        // Stall in DONE with a competing query offered
        start_query(50'hFF_FFFF_FFFF, 5'd9);
        wait_done(n);
        @(negedge clk);
        in_valid    = 1'b1;
        query_hv    = 50'hF0_0000_0001;
        query_class = 5'd5;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            chk("stall_inference", {59'd0, o0_inference}, 64'd9);
            chk("stall_score", {58'd0, o0_best_score}, 64'd36);
            chk("stall_valid", {63'd0, o0_out_valid}, 64'd1);
            chk("stall_in_ready", {63'd0, o0_in_ready}, 64'd0);
        end
        in_valid = 1'b0;
        handshake(1'b0);
        chk("stall_qcnt", {48'd0, o0_query_cnt}, 64'd7);
        chk("stall_ccnt", {48'd0, o0_correct_cnt}, 64'd5);
        chk("stall_idle_after", {63'd0, o0_busy}, 64'd0);

        // Write during SCAN is ignored
        start_query(50'hFF_FFFF_FFFF, 5'd9);
        repeat (3) @(negedge clk);
        wr_en = 1'b1; wr_addr = 5'd9; wr_hv = '0;
        @(negedge clk);
        wr_en = 1'b0;
        wait_done(n);
        chk("scanwr_inference", {59'd0, o0_inference}, 64'd9);
        chk("scanwr_score", {58'd0, o0_best_score}, 64'd36);
        handshake(1'b0);

        // Write and query on the same IDLE edge: scan sees the new data
        @(negedge clk);
        wr_en = 1'b1; wr_addr = 5'd9; wr_hv = '0;
        in_valid = 1'b1; query_hv = 50'hFF_FFFF_FFFF; query_class = 5'd9;
        @(posedge clk);
        #1;
        wr_en = 1'b0; in_valid = 1'b0;
        wait_done(n);
        chk("idlewr_latency", 64'(n), 64'd26);
        chk("idlewr_inference", {59'd0, o0_inference}, 64'd16);
        chk("idlewr_score", {58'd0, o0_best_score}, 64'd32);
        handshake(1'b0);
        chk("idlewr_qcnt", {48'd0, o0_query_cnt}, 64'd9);
        chk("idlewr_ccnt", {48'd0, o0_correct_cnt}, 64'd6);
        write_cls(9, 50'hF_FFFF_FFFF);

        // Reset pulse mid-SCAN aborts the query
        start_query(50'hFF_FFFF_FFFF, 5'd9);
        repeat (5) @(posedge clk);
        @(negedge clk);
        #1 nrst = 1'b0;
        #1;
        chk("abort_out_valid", {63'd0, o0_out_valid}, 64'd0);
        chk("abort_busy", {63'd0, o0_busy}, 64'd0);
        chk("abort_qcnt", {48'd0, o0_query_cnt}, 64'd0);
        chk("abort_ccnt", {48'd0, o0_correct_cnt}, 64'd0);
        chk("abort_in_ready", {63'd0, o0_in_ready}, 64'd1);
        #1 nrst = 1'b1;
        start_query(50'hFF_FFFF_FFFF, 5'd9);
        wait_done(n);
        chk("post_abort_latency", 64'(n), 64'd26);
        chk("post_abort_inference", {59'd0, o0_inference}, 64'd9);
        handshake(1'b0);
        chk("post_abort_qcnt", {48'd0, o0_query_cnt}, 64'd1);
        chk("post_abort_ccnt", {48'd0, o0_correct_cnt}, 64'd1);

        // stat_clr on the handshake edge wins over the increment
        start_query(50'hFF_FFFF_FFFF, 5'd9);
        wait_done(n);
        handshake(1'b1);
        chk("clr_qcnt", {48'd0, o0_query_cnt}, 64'd0);
        chk("clr_ccnt", {48'd0, o0_correct_cnt}, 64'd0);
        chk("clr_qcnt1", {48'd0, o1_query_cnt}, 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
